dmem_responder: RTL and testbench
=================================

# dmem_responder

Word-addressed data-memory responder that serves load/store requests from the CPU's MEM stage over a request/ready handshake with a programmable number of wait states. It is the memory-side counterpart to the pipeline's data-memory port: the pipeline initiates, this block accepts, stalls the initiator while busy, and returns read data or commits the write. It replaces the zero-latency data memory when realistic memory timing is modelled.

## Interface
Parameters:
- DEPTH_LOG2, 6, log2 of the number of 32-bit words (64 words by default).
- WAIT_CYCLES, 2, extra cycles between capture and response (0..15).

Ports:
- Clk  in  1  clock; all state changes on the rising edge.
- Clrn  in  1  reset; asynchronous, active-low.
- Req  in  1  initiator request; held high until Ready is seen.
- Wmem  in  1  1 = store, 0 = load; sampled with Req.
- Addr  in  32  byte address; word index is Addr[DEPTH_LOG2+1:2].
- Wdata  in  32  store data; sampled with Req.
- Rdata  out  32  load data; valid in the Ready cycle, held until the next response.
- Ready  out  1  one-cycle response strobe.
- Busy  out  1  pipeline stall; combinational Req & ~Ready.
- Err  out  1  alignment error; present only with DMEM_ALIGN_CHK_EN.

## Operation
- FSM states: IDLE, WAIT, RESP.
- IDLE: when Req=1, latch Addr, Wmem, Wdata, load counter with WAIT_CYCLES, go to WAIT (go straight to RESP if WAIT_CYCLES=0).
- WAIT: decrement counter each cycle; when counter reaches 1 (or is 0 at entry), go to RESP on the next edge.
- Edge entering RESP: a store writes Wdata to the array at the latched word index; a load registers array[index] into Rdata. For a store, Rdata keeps its previous value.
- RESP: Ready=1 for exactly one cycle; the next state is always IDLE.
- Inputs are ignored outside IDLE. Changes to Addr/Wdata after capture have no effect.
- Addr bits above DEPTH_LOG2+1 are ignored, so addresses alias modulo 4·2^DEPTH_LOG2 bytes.
- Array contents are not reset and are undefined until written.

## Timing
- Reset values: state IDLE, counter 0, Ready 0, Rdata 0, Err 0. Busy follows Req.
- Latency: capture edge at t means Ready is high during cycle t+WAIT_CYCLES+1.
- Back-to-back requests: if Req is still high in the cycle after Ready, that cycle is IDLE and it is captured as a new request. The minimum spacing is WAIT_CYCLES+2 cycles per transaction.
- Busy is high in the capture cycle and in every WAIT cycle, and low in the Ready cycle, so the pipeline advances exactly on Ready.
- Reset asserted mid-transaction: the transaction is aborted and Ready does not fire. A store is not committed unless the RESP-entry edge has already occurred.
- Req dropped before Ready (protocol violation): the transaction still completes, and Ready pulses once.

## Configuration
- DMEM_ALIGN_CHK_EN defined:
  - Err port exists.
  - Addr[1:0]≠0 at capture sets a latched error flag.
  - In RESP, Err=1 alongside Ready, the store is suppressed, and Rdata is forced to 0.
  - Err is cleared when the next transaction is captured.
- Not defined:
  - No Err port.
  - Addr[1:0] is ignored and accesses round down to the word.

## Structure
- dmem_pkg: state enum (IDLE/WAIT/RESP), counter width constant (4 bits), and the word-index slice helper constant.
- One sub-module, dmem_array: 2^DEPTH_LOG2 × 32 storage with synchronous write and asynchronous read, instantiated once.
- FSM, counter and output registers stay in the top level.

## Test plan
- Reset with Clrn=0 mid-WAIT, then release → Ready, Rdata and Err are 0, and the next Req is captured normally from IDLE.
- WAIT_CYCLES=2: store 0xDEADBEEF to 0x10, then load 0x10 → each Ready fires 3 cycles after capture, and the load returns 0xDEADBEEF.
- Back-to-back loads from 0x10 and 0x14 with Req held → Ready pulses exactly 4 cycles apart, and Busy is low only in the Ready cycles.
- DEPTH_LOG2=6: store 0x12345678 to 0x104, then load 0x004 → returns 0x12345678 (aliasing).
- WAIT_CYCLES=0: a load is Ready 1 cycle after capture, and Busy is high for exactly 1 cycle.
- With DMEM_ALIGN_CHK_EN: store 0xFFFFFFFF to 0x22, then load 0x20 → Err=1 with the first Ready and Rdata=0. The load returns the prior contents, and Err is 0 on the second Ready.

Source files
------------

// File: rtl/dmem_pkg.sv
// dmem_pkg: shared types and constants for the data-memory responder.
//   state_t  : responder FSM states (IDLE / WAIT / RESP)
//   CNT_W    : wait-state counter width (WAIT_CYCLES range 0..15)
//   WORD_LSB : lowest byte-address bit of the word index
package dmem_pkg;

  localparam int unsigned DATA_W   = 32;
  localparam int unsigned ADDR_W   = 32;
  localparam int unsigned CNT_W    = 4;
  localparam int unsigned WORD_LSB = 2;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;

endpackage

// File: rtl/dmem_array.sv
// dmem_array: 2^DEPTH_LOG2 x 32-bit word storage, synchronous write, asynchronous read.
// Ports:
//   clk   : write clock
//   we    : write enable
//   idx   : word index shared by read and write
//   wdata : write data
//   rdata : combinational read data at idx
// Contents are not reset.
module dmem_array
  import dmem_pkg::*;
#(
  parameter int unsigned DEPTH_LOG2 = 6
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic [DEPTH_LOG2-1:0] idx,
  input  logic [DATA_W-1:0]     wdata,
  output logic [DATA_W-1:0]     rdata
);

  localparam int unsigned DEPTH = 1 << DEPTH_LOG2;

  logic [DATA_W-1:0] mem [DEPTH];

  // Write port
  always_ff @(posedge clk) begin
    if (we) begin
      mem[idx] <= wdata;
    end
  end

  // Read port
  assign rdata = mem[idx];

endmodule

// File: rtl/dmem_responder.sv
// dmem_responder: word-addressed data-memory responder with programmable wait states.
// Accepts one load/store per Req/Ready handshake and answers WAIT_CYCLES+1 cycles after capture.
// Optional feature macro: DMEM_ALIGN_CHK_EN (adds Err port and misaligned-access suppression).
// Ports:
//   Clk   : clock
//   Clrn  : asynchronous active-low reset
//   Req   : request, held until Ready
//   Wmem  : 1 = store, 0 = load (sampled with Req)
//   Addr  : byte address; word index = Addr[DEPTH_LOG2+1:2]
//   Wdata : store data (sampled with Req)
//   Rdata : load data, registered, held between responses
//   Ready : one-cycle response strobe, registered
//   Busy  : combinational stall, Req & ~Ready
//   Err   : misalignment flag shown with Ready (DMEM_ALIGN_CHK_EN only)
module dmem_responder
  import dmem_pkg::*;
#(
  parameter int unsigned DEPTH_LOG2  = 6,
  parameter int unsigned WAIT_CYCLES = 2
) (
  input  logic              Clk,
  input  logic              Clrn,
  input  logic              Req,
  input  logic              Wmem,
  input  logic [ADDR_W-1:0] Addr,
  input  logic [DATA_W-1:0] Wdata,
  output logic [DATA_W-1:0] Rdata,
  output logic              Ready,
  output logic              Busy
`ifdef DMEM_ALIGN_CHK_EN
  ,
  output logic              Err
`endif
);

  state_t                state_q, state_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [DEPTH_LOG2-1:0] idx_q;
  logic                  wmem_q;
  logic [DATA_W-1:0]     wdata_q;

  logic                  capture_c;
  logic                  resp_entry_c;
  logic [DEPTH_LOG2-1:0] acc_idx_c;
  logic                  acc_wmem_c;
  logic [DATA_W-1:0]     acc_wdata_c;
  logic                  acc_err_c;
  logic                  mem_we_c;
  logic [DATA_W-1:0]     mem_rdata;

  assign capture_c    = (state_q == IDLE) && Req;
  assign resp_entry_c = (state_d == RESP) && (state_q != RESP);

  // With zero wait states the RESP-entry edge is the capture edge, so the
  // access must come straight from the inputs rather than the latched copy.
  always_comb begin
    acc_idx_c   = idx_q;
    acc_wmem_c  = wmem_q;
    acc_wdata_c = wdata_q;
    if (state_q == IDLE) begin
      acc_idx_c   = Addr[DEPTH_LOG2+WORD_LSB-1:WORD_LSB];
      acc_wmem_c  = Wmem;
      acc_wdata_c = Wdata;
    end
  end

`ifdef DMEM_ALIGN_CHK_EN
  logic err_flag_q;
  logic unused_addr_c;

  assign acc_err_c     = (state_q == IDLE) ? (Addr[WORD_LSB-1:0] != '0) : err_flag_q;
  assign unused_addr_c = ^Addr[ADDR_W-1:DEPTH_LOG2+WORD_LSB];

  // Latched misalignment flag and the Err output shown with Ready
  always_ff @(posedge Clk or negedge Clrn) begin
    if (!Clrn) begin
      err_flag_q <= 1'b0;
      Err        <= 1'b0;
    end else begin
      if (capture_c) begin
        err_flag_q <= (Addr[WORD_LSB-1:0] != '0);
      end
      if (resp_entry_c) begin
        Err <= acc_err_c;
      end else if (capture_c) begin
        Err <= 1'b0;
      end
    end
  end
`else
  logic unused_addr_c;

  // Byte-offset bits are dropped: accesses round down to the word
  assign acc_err_c     = 1'b0;
  assign unused_addr_c = ^{Addr[ADDR_W-1:DEPTH_LOG2+WORD_LSB], Addr[WORD_LSB-1:0]};
`endif

  assign mem_we_c = resp_entry_c && acc_wmem_c && !acc_err_c;

  dmem_array #(
    .DEPTH_LOG2 (DEPTH_LOG2)
  ) u_array (
    .clk   (Clk),
    .we    (mem_we_c),
    .idx   (acc_idx_c),
    .wdata (acc_wdata_c),
    .rdata (mem_rdata)
  );

  // Next-state and wait-counter logic
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      IDLE: begin
        if (Req) begin
          cnt_d   = CNT_W'(WAIT_CYCLES);
          state_d = (WAIT_CYCLES == 0) ? RESP : WAIT;
        end
      end
      WAIT: begin
        if (cnt_q <= CNT_W'(1)) begin
          state_d = RESP;
        end
        if (cnt_q != '0) begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      RESP: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State, counter and capture registers
  always_ff @(posedge Clk or negedge Clrn) begin
    if (!Clrn) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
      wmem_q  <= 1'b0;
      wdata_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (capture_c) begin
        idx_q   <= Addr[DEPTH_LOG2+WORD_LSB-1:WORD_LSB];
        wmem_q  <= Wmem;
        wdata_q <= Wdata;
      end
    end
  end

  // Response registers: Ready strobe and load data (stores leave Rdata alone)
  always_ff @(posedge Clk or negedge Clrn) begin
    if (!Clrn) begin
      Ready <= 1'b0;
      Rdata <= '0;
    end else begin
      Ready <= resp_entry_c;
      if (resp_entry_c) begin
        if (acc_err_c) begin
          Rdata <= '0;
        end else if (!acc_wmem_c) begin
          Rdata <= mem_rdata;
        end
      end
    end
  end

  assign Busy = Req & ~Ready;

endmodule

// File: tb/tb_dmem_responder.sv
// tb_dmem_responder: randomized and directed self-checking bench for dmem_responder.
// u_dut runs with WAIT_CYCLES=2 against a word-array reference model; u_dut0 covers WAIT_CYCLES=0.
// Build with DMEM_ALIGN_CHK_EN defined to exercise the Err path.
module tb_dmem_responder;

  localparam int unsigned DL2 = 6;
  localparam int unsigned WC  = 2;
  localparam int unsigned NW  = 1 << DL2;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req, wmem;
  logic [31:0] addr, wdata, rdata;
  logic        ready, busy;
  logic        req0, wmem0;
  logic [31:0] addr0, wdata0, rdata0;
  logic        ready0, busy0;
`ifdef DMEM_ALIGN_CHK_EN
  logic        err, err0;
`endif

  int n_cmp = 0;
  int n_mis = 0;
  int cyc   = 0;

  // Reference model: word array with written-flags and the last Rdata value
  logic [31:0] ref_mem [NW];
  bit          ref_vld [NW];
  logic [31:0] ref_rdata;
  bit          ref_rknown;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  dmem_responder #(.DEPTH_LOG2(DL2), .WAIT_CYCLES(WC)) u_dut (
    .Clk   (clk),
    .Clrn  (rst_n),
    .Req   (req),
    .Wmem  (wmem),
    .Addr  (addr),
    .Wdata (wdata),
    .Rdata (rdata),
    .Ready (ready),
    .Busy  (busy)
`ifdef DMEM_ALIGN_CHK_EN
    ,
    .Err   (err)
`endif
  );

  dmem_responder #(.DEPTH_LOG2(DL2), .WAIT_CYCLES(0)) u_dut0 (
    .Clk   (clk),
    .Clrn  (rst_n),
    .Req   (req0),
    .Wmem  (wmem0),
    .Addr  (addr0),
    .Wdata (wdata0),
    .Rdata (rdata0),
    .Ready (ready0),
    .Busy  (busy0)
`ifdef DMEM_ALIGN_CHK_EN
    ,
    .Err   (err0)
`endif
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_mis++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // One transaction on u_dut; returns the cycle number of its Ready
  task automatic do_txn(input bit wr, input logic [31:0] a, input logic [31:0] d,
                        input bit keep, output int rc);
    int idx;
    bit mis;
    bit seen;
    int lat;
    idx = int'((a >> 2) % NW);
`ifdef DMEM_ALIGN_CHK_EN
    mis = (a % 4) != 0;
`else
    mis = 1'b0;
`endif
    @(posedge clk);
    #1;
    req = 1'b1; wmem = wr; addr = a; wdata = d;
    seen = 1'b0; lat = 0; rc = 0;
    for (int k = 0; k < 40 && !seen; k++) begin
      @(negedge clk);
      if (ready === 1'b1) begin
        seen = 1'b1;
        lat  = k;
        rc   = cyc;
      end else begin
        chk("busy_wait", {31'd0, busy}, 32'd1);
        if (k >= 1) begin
          addr  = $urandom;
          wdata = $urandom;
        end
      end
    end
    if (!seen) chk("ready_timeout", {31'd0, ready}, 32'd1);
    chk("latency", 32'(lat), 32'(WC + 1));
    chk("busy_ready", {31'd0, busy}, 32'd0);
    if (mis) begin
      ref_rdata  = 32'd0;
      ref_rknown = 1'b1;
    end else if (wr) begin
      ref_mem[idx] = d;
      ref_vld[idx] = 1'b1;
    end else begin
      ref_rknown = ref_vld[idx];
      ref_rdata  = ref_mem[idx];
    end
    if (ref_rknown) chk(wr ? "rdata_hold" : "rdata_load", rdata, ref_rdata);
`ifdef DMEM_ALIGN_CHK_EN
    chk("err", {31'd0, err}, {31'd0, mis});
`endif
    if (!keep) req = 1'b0;
  endtask

  // One transaction on the zero-wait-state instance
  task automatic do_txn0(input bit wr, input logic [31:0] a, input logic [31:0] d,
                         input logic [31:0] exp_rd);
    bit seen;
    int lat;
    @(posedge clk);
    #1;
    req0 = 1'b1; wmem0 = wr; addr0 = a; wdata0 = d;
    seen = 1'b0; lat = 0;
    for (int k = 0; k < 20 && !seen; k++) begin
      @(negedge clk);
      if (ready0 === 1'b1) begin
        seen = 1'b1;
        lat  = k;
      end else begin
        chk("w0_busy_wait", {31'd0, busy0}, 32'd1);
      end
    end
    if (!seen) chk("w0_ready_timeout", {31'd0, ready0}, 32'd1);
    chk("w0_latency", 32'(lat), 32'd1);
    chk("w0_busy_ready", {31'd0, busy0}, 32'd0);
    chk("w0_rdata", rdata0, exp_rd);
    req0 = 1'b0;
  endtask

  initial begin
    int          rc1, rc2, rc;
    int          pulses;
    logic [31:0] ra, rd;
    bit          rw, rk;

    rst_n = 1'b0;
    req = 1'b0; wmem = 1'b0; addr = '0; wdata = '0;
    req0 = 1'b0; wmem0 = 1'b0; addr0 = '0; wdata0 = '0;
    ref_rdata = 32'd0; ref_rknown = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_ready", {31'd0, ready}, 32'd0);
    chk("rst_rdata", rdata, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_ready0", {31'd0, ready0}, 32'd0);
`ifdef DMEM_ALIGN_CHK_EN
    chk("rst_err", {31'd0, err}, 32'd0);
`endif
    rst_n = 1'b1;

    // Store then load, aliasing and back-to-back loads
    do_txn(1'b1, 32'h10, 32'hDEADBEEF, 1'b0, rc);
    do_txn(1'b0, 32'h10, 32'h0, 1'b0, rc);
    do_txn(1'b1, 32'h14, 32'h5A5A0014, 1'b0, rc);
    do_txn(1'b0, 32'h10, 32'h0, 1'b1, rc1);
    do_txn(1'b0, 32'h14, 32'h0, 1'b0, rc2);
    chk("b2b_spacing", 32'(rc2 - rc1), 32'(WC + 2));
    do_txn(1'b1, 32'h104, 32'h12345678, 1'b0, rc);
    do_txn(1'b0, 32'h004, 32'h0, 1'b0, rc);

    // Misaligned store between two accesses to the same word
    do_txn(1'b1, 32'h20, 32'h0BADF00D, 1'b0, rc);
    do_txn(1'b1, 32'h22, 32'hFFFFFFFF, 1'b0, rc);
    do_txn(1'b0, 32'h20, 32'h0, 1'b0, rc);

    // Zero-wait-state instance: store, load, aliased store, load
    do_txn0(1'b1, 32'h8, 32'hCAFEF00D, 32'h0);
    do_txn0(1'b0, 32'h8, 32'h0, 32'hCAFEF00D);
    do_txn0(1'b1, 32'h108, 32'h00000001, 32'hCAFEF00D);
    do_txn0(1'b0, 32'h8, 32'h0, 32'h00000001);

    // Reset in the middle of a store's WAIT phase aborts it
    @(posedge clk);
    #1;
    req = 1'b1; wmem = 1'b1; addr = 32'h10; wdata = 32'h11111111;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    req = 1'b0;
    chk("midrst_ready", {31'd0, ready}, 32'd0);
    chk("midrst_rdata", rdata, 32'd0);
`ifdef DMEM_ALIGN_CHK_EN
    chk("midrst_err", {31'd0, err}, 32'd0);
`endif
    ref_rdata = 32'd0; ref_rknown = 1'b1;
    @(negedge clk);
    rst_n = 1'b1;
    do_txn(1'b0, 32'h10, 32'h0, 1'b0, rc);

    // Req dropped right after capture: the load still completes once
    @(posedge clk);
    #1;
    req = 1'b1; wmem = 1'b0; addr = 32'h14;
    @(posedge clk);
    #1;
    req = 1'b0;
    pulses = 0;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      if (ready === 1'b1) pulses++;
    end
    chk("drop_req_pulses", 32'(pulses), 32'd1);
    chk("drop_req_rdata", rdata, ref_mem[5]);
    ref_rdata = ref_mem[5]; ref_rknown = 1'b1;

    // Randomized traffic against the reference model
    for (int i = 0; i < 60; i++) begin
      ra = $urandom;
`ifdef DMEM_ALIGN_CHK_EN
      if ($urandom_range(0, 3) != 0) ra = ra & 32'hFFFFFFFC;
`endif
      rd = $urandom;
      rw = 1'($urandom_range(0, 1));
      rk = 1'($urandom_range(0, 1));
      do_txn(rw, ra, rd, rk, rc);
    end
    req = 1'b0;
    repeat (2) @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
